// File: rtl/line_unrng.sv
// line_unrng: column serializer. Takes one window word of ODATA_RNG columns
// and replays it one column per consumed cycle, oldest column first.
// A single pending slot lets the next word be accepted while the current one
// is still draining, so back-to-back words play out with no bubble.
// Optional build macro: LINE_UNRNG_CHK_EN adds the sticky o_err overrun flag.
module line_unrng #(
  parameter int DBUF_DW   = 8,
  parameter int KRNV_SZ   = 6,
  parameter int ODATA_RNG = 2   // must be >= 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [DBUF_DW*KRNV_SZ*ODATA_RNG-1:0] i_data,
  input  logic                                 i_dvld,
  input  logic                                 i_hstr,
  input  logic                                 i_hend,
  input  logic                                 i_vstr,
  input  logic                                 i_vend,
  output logic                                 o_rdy,
  input  logic                                 i_rdy,
  output logic [DBUF_DW*KRNV_SZ-1:0]           o_data,
  output logic                                 o_dvld,
  output logic                                 o_hstr,
  output logic                                 o_vstr,
  output logic                                 o_hend,
  output logic                                 o_vend
`ifdef LINE_UNRNG_CHK_EN
  ,
  output logic                                 o_err
`endif
);

  localparam int W  = DBUF_DW * KRNV_SZ;
  localparam int CW = $clog2(ODATA_RNG);

  // Element [ODATA_RNG-1] is the oldest column, [0] the newest.
  typedef logic [ODATA_RNG-1:0][W-1:0] word_t;

  typedef struct packed {
    logic hstr;
    logic vstr;
    logic hend;
    logic vend;
  } flg_t;

  typedef enum logic [1:0] {
    IDLE = 2'b01,
    SEND = 2'b10
  } state_t;

  state_t          state, nxt;
  word_t           din, sft, pnd;
  flg_t            fin, sft_f, pnd_f;
  logic            pnd_vld;
  logic [CW-1:0]   col_cnt;

  logic            acc, cons, last;
  logic            ld_in, ld_pnd, shift, wr_pnd, clr_pnd;

  assign din  = i_data;
  assign fin  = '{hstr: i_hstr, vstr: i_vstr, hend: i_hend, vend: i_vend};

  // Ready depends only on the pending slot, never on i_dvld.
  assign o_rdy = ~pnd_vld;
  assign acc   = i_dvld & o_rdy;
  assign cons  = (state == SEND) & i_rdy;
  assign last  = (col_cnt == CW'(ODATA_RNG - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  // Next state and datapath load/shift controls
  always_comb begin
    nxt     = state;
    ld_in   = 1'b0;
    ld_pnd  = 1'b0;
    shift   = 1'b0;
    wr_pnd  = 1'b0;
    clr_pnd = 1'b0;
    unique case (state)
      IDLE: begin
        if (acc) begin
          nxt   = SEND;
          ld_in = 1'b1;
        end
      end
      SEND: begin
        if (cons && last) begin
          // Reload from pending first; the incoming word (if any) refills it.
          if (pnd_vld) begin
            ld_pnd = 1'b1;
            if (acc) wr_pnd  = 1'b1;
            else     clr_pnd = 1'b1;
          end else if (acc) begin
            ld_in = 1'b1;
          end else begin
            nxt   = IDLE;
            shift = 1'b1;   // flushes the last column so sft ends up empty
          end
        end else begin
          if (cons) shift  = 1'b1;
          if (acc)  wr_pnd = 1'b1;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  // Shift register, pending slot and column counter
  always_ff @(posedge clk) begin
    if (rst) begin
      sft     <= '0;
      sft_f   <= '0;
      pnd     <= '0;
      pnd_f   <= '0;
      pnd_vld <= 1'b0;
      col_cnt <= '0;
    end else begin
      if (ld_in) begin
        sft     <= din;
        sft_f   <= fin;
        col_cnt <= '0;
      end else if (ld_pnd) begin
        sft     <= pnd;
        sft_f   <= pnd_f;
        col_cnt <= '0;
      end else if (shift) begin
        sft     <= {sft[ODATA_RNG-2:0], {W{1'b0}}};
        col_cnt <= last ? '0 : col_cnt + CW'(1);
      end
      if (wr_pnd) begin
        pnd     <= din;
        pnd_f   <= fin;
        pnd_vld <= 1'b1;
      end else if (clr_pnd) begin
        pnd_vld <= 1'b0;
      end
    end
  end

  assign o_dvld = (state == SEND);
  assign o_data = sft[ODATA_RNG-1];
  assign o_hstr = sft_f.hstr & (col_cnt == '0) & o_dvld;
  assign o_vstr = sft_f.vstr & (col_cnt == '0) & o_dvld;
  assign o_hend = sft_f.hend & last & o_dvld;
  assign o_vend = sft_f.vend & last & o_dvld;

`ifdef LINE_UNRNG_CHK_EN
  logic err_q;

  // Sticky record of any word offered while the pending slot was full
  always_ff @(posedge clk) begin
    if (rst)                   err_q <= 1'b0;
    else if (i_dvld & ~o_rdy)  err_q <= 1'b1;
  end

  assign o_err = err_q;
`endif

endmodule

// File: tb/tb_line_unrng.sv
// tb_line_unrng: drives two serializers (2 and 4 columns per word) and checks
// every cycle against a column-queue reference model.
module tb_line_unrng;

  localparam int W = 48;

  typedef struct packed {
    logic [W-1:0] d;
    logic [3:0]   f;   // {hstr, vstr, hend, vend}
  } col_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic [2*W-1:0] idat2;
  logic [4*W-1:0] idat4;
  logic           dv [2];
  logic           rd [2];
  logic           hs, vs, he, ve;
  logic           ordy [2], odv [2], ohs [2], ovs [2], ohe [2], ove [2];
  logic [W-1:0]   od [2];
`ifdef LINE_UNRNG_CHK_EN
  logic           oerr [2];
  bit             merr [2];
`endif

  line_unrng #(.ODATA_RNG(2)) u_r2 (
    .clk(clk), .rst(rst), .i_data(idat2), .i_dvld(dv[0]),
    .i_hstr(hs), .i_hend(he), .i_vstr(vs), .i_vend(ve),
    .o_rdy(ordy[0]), .i_rdy(rd[0]), .o_data(od[0]), .o_dvld(odv[0]),
    .o_hstr(ohs[0]), .o_vstr(ovs[0]), .o_hend(ohe[0]), .o_vend(ove[0])
`ifdef LINE_UNRNG_CHK_EN
    , .o_err(oerr[0])
`endif
  );

  line_unrng #(.ODATA_RNG(4)) u_r4 (
    .clk(clk), .rst(rst), .i_data(idat4), .i_dvld(dv[1]),
    .i_hstr(hs), .i_hend(he), .i_vstr(vs), .i_vend(ve),
    .o_rdy(ordy[1]), .i_rdy(rd[1]), .o_data(od[1]), .o_dvld(odv[1]),
    .o_hstr(ohs[1]), .o_vstr(ovs[1]), .o_hend(ohe[1]), .o_vend(ove[1])
`ifdef LINE_UNRNG_CHK_EN
    , .o_err(oerr[1])
`endif
  );

  // Reference: every accepted word becomes its columns in a FIFO; the head is
  // what should be on the output, consumption pops it.
  col_t         q [2][$];
  bit           clean [2];        // nothing accepted since reset
  logic [W-1:0] wc [2][4];        // columns of the word currently offered
  int           n_cmp = 0;
  int           n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int rng(input int n);
    return (n == 0) ? 2 : 4;
  endfunction

  // At most two words may be held: the one playing and one waiting.
  function automatic bit mrdy(input int n);
    return ((q[n].size() + rng(n) - 1) / rng(n)) < 2;
  endfunction

  task automatic load(input int n);
    if (n == 0) for (int k = 0; k < 2; k++) idat2[W*(2-k)-1 -: W] = wc[0][k];
    else        for (int k = 0; k < 4; k++) idat4[W*(4-k)-1 -: W] = wc[1][k];
  endtask

  task automatic rnd_word(input int n);
    logic [63:0] t;
    for (int k = 0; k < 4; k++) begin
      t = {$urandom, $urandom};
      wc[n][k] = t[W-1:0];
    end
    load(n);
  endtask

  task automatic check(input int n);
    col_t  e;
    bit    v;
    string p;
    p = $sformatf("r%0d_", rng(n));
    v = q[n].size() > 0;
    e = v ? q[n][0] : '0;
    chk({p, "dvld"}, 64'(odv[n]), 64'(v));
    if (v || clean[n]) chk({p, "data"}, 64'(od[n]), 64'(e.d));
    chk({p, "flags"}, 64'({ohs[n], ovs[n], ohe[n], ove[n]}), 64'(e.f));
    chk({p, "rdy"}, 64'(ordy[n]), 64'(mrdy(n)));
`ifdef LINE_UNRNG_CHK_EN
    chk({p, "err"}, 64'(oerr[n]), 64'(merr[n]));
`endif
  endtask

  // One clock: inputs are already set; update the model at the edge, check
  // outputs on the following falling edge.
  task automatic tick();
    bit       acc [2], con [2], vio [2];
    logic [3:0] fl;
    col_t     c;
    fl = {hs, vs, he, ve};
    for (int n = 0; n < 2; n++) begin
      acc[n] = dv[n] && mrdy(n);
      vio[n] = dv[n] && !mrdy(n);
      con[n] = rd[n] && (q[n].size() > 0);
    end
    @(posedge clk);
    for (int n = 0; n < 2; n++) begin
      if (rst) begin
        q[n].delete();
        clean[n] = 1'b1;
`ifdef LINE_UNRNG_CHK_EN
        merr[n] = 1'b0;
`endif
      end else begin
        if (con[n]) void'(q[n].pop_front());
        if (acc[n]) begin
          clean[n] = 1'b0;
          for (int k = 0; k < rng(n); k++) begin
            c.d = wc[n][k];
            c.f = {fl[3] & (k == 0), fl[2] & (k == 0),
                   fl[1] & (k == rng(n) - 1), fl[0] & (k == rng(n) - 1)};
            q[n].push_back(c);
          end
        end
`ifdef LINE_UNRNG_CHK_EN
        if (vio[n]) merr[n] = 1'b1;
`else
        if (vio[n]) c = '0;   // offered word is simply dropped
`endif
      end
    end
    @(negedge clk);
    check(0);
    check(1);
  endtask

  task automatic idle_in();
    dv[0] = 1'b0; dv[1] = 1'b0;
    {hs, vs, he, ve} = 4'b0000;
  endtask

  initial begin
    rst = 1'b1;
    idat2 = '0; idat4 = '0;
    dv = '{1'b0, 1'b0}; rd = '{1'b1, 1'b1};
    {hs, vs, he, ve} = 4'b0000;
    clean = '{1'b1, 1'b1};
`ifdef LINE_UNRNG_CHK_EN
    merr = '{1'b0, 1'b0};
`endif
    @(negedge clk);
    // Reset state
    tick(); tick();
    rst = 1'b0;
    tick();

    // Single word: AAAA.. oldest, 5555.. newest, hstr+hend
    wc[0][0] = 48'hAAAA_AAAA_AAAA;
    wc[0][1] = 48'h5555_5555_5555;
    load(0);
    {hs, vs, he, ve} = 4'b1010;
    dv[0] = 1'b1;
    tick();
    idle_in();
    repeat (3) tick();

    // Four-column word with vstr+vend
    rnd_word(1);
    {hs, vs, he, ve} = 4'b0101;
    dv[1] = 1'b1;
    tick();
    idle_in();
    repeat (6) tick();

    // Back-to-back words, offered whenever ready
    repeat (20) begin
      for (int n = 0; n < 2; n++) begin
        rnd_word(n);
        dv[n] = mrdy(n);
      end
      {hs, vs, he, ve} = 4'($urandom);
      tick();
    end
    idle_in();
    repeat (8) tick();

    // Stall mid-word with a word waiting in the pending slot
    for (int i = 0; i < 2; i++) begin
      rnd_word(0); rnd_word(1);
      dv[0] = 1'b1; dv[1] = 1'b1;
      {hs, vs, he, ve} = 4'($urandom);
      tick();
    end
    idle_in();
    rd = '{1'b0, 1'b0};
    repeat (3) tick();
    rd = '{1'b1, 1'b1};
    repeat (10) tick();

    // Reset while playing with the pending slot full, then a fresh word
    for (int i = 0; i < 2; i++) begin
      rnd_word(0); rnd_word(1);
      dv[0] = 1'b1; dv[1] = 1'b1;
      tick();
    end
    idle_in();
    rd = '{1'b0, 1'b0};
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rd = '{1'b1, 1'b1};
    rnd_word(0); rnd_word(1);
    {hs, vs, he, ve} = 4'b1111;
    dv[0] = 1'b1; dv[1] = 1'b1;
    tick();
    idle_in();
    repeat (6) tick();

    // Offer a word while not ready: dropped, never shows up
    rd = '{1'b0, 1'b0};
    for (int i = 0; i < 2; i++) begin
      rnd_word(0); rnd_word(1);
      dv[0] = 1'b1; dv[1] = 1'b1;
      tick();
    end
    for (int n = 0; n < 2; n++)
      for (int k = 0; k < 4; k++) wc[n][k] = 48'hDEAD_BEEF_0BAD;
    load(0); load(1);
    tick();
    idle_in();
    rd = '{1'b1, 1'b1};
    repeat (12) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    // Random traffic, back-pressure, occasional violations and resets
    repeat (3000) begin
      for (int n = 0; n < 2; n++) begin
        rnd_word(n);
        dv[n] = mrdy(n) ? ($urandom_range(9) < 6) : ($urandom_range(19) == 0);
        rd[n] = $urandom_range(9) < 7;
      end
      {hs, vs, he, ve} = 4'($urandom);
      rst = ($urandom_range(199) == 0);
      tick();
    end
    rst = 1'b0;
    idle_in();
    rd = '{1'b1, 1'b1};
    repeat (10) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/line_unrng.md
# line_unrng

Column serializer: the inverse of the line range collector. It accepts one wide window word holding ODATA_RNG consecutive columns, each of KRNV_SZ pixels, and replays them one column per accepted output cycle, oldest column first. Frame/line sync flags are re-timed onto the first or last column. It sits after window-level processing and returns data to column-rate consumers such as line buffers and writers.

## Interface
- DBUF_DW, 8, pixel width
- KRNV_SZ, 6, pixels per column (vertical kernel size)
- ODATA_RNG, 2, columns per input word; legal range ≥ 2
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- i_data  input  DBUF_DW*KRNV_SZ*ODATA_RNG  window word; slice [W*ODATA_RNG-1 -: W] is the oldest column, [W-1:0] the newest, where W = DBUF_DW*KRNV_SZ
- i_dvld  input  1  i_data valid
- i_hstr, i_hend, i_vstr, i_vend  input  1 each  sync flags qualified by i_dvld
- o_rdy  output  1  word accepted when i_dvld & o_rdy
- i_rdy  input  1  downstream ready; column consumed when o_dvld & i_rdy
- o_data  output  W  current column
- o_dvld  output  1  o_data valid
- o_hstr, o_vstr  output  1 each  flags on the first column of a word
- o_hend, o_vend  output  1 each  flags on the last column of a word
- o_err  output  1  sticky overrun flag; present only with LINE_UNRNG_CHK_EN

## Operation
- Storage:
  - Shift register sft (W*ODATA_RNG) with flag bits sft_hstr/vstr/hend/vend.
  - Pending register pnd (same width) with flags and valid bit pnd_vld.
  - Column counter col_cnt, width $clog2(ODATA_RNG).
- FSM, one-hot:
  - IDLE: sft empty, o_dvld=0.
  - SEND: sft holds a word and o_dvld=1.
- Transitions:
  - IDLE → SEND on accept. The word loads directly into sft and col_cnt=0.
  - SEND, column consumed with col_cnt<ODATA_RNG-1: sft shifts left by W (zero fill) and col_cnt increments.
  - SEND, last column consumed (col_cnt==ODATA_RNG-1):
    - If pnd_vld, or an accept occurs in the same cycle: load that word into sft (pnd takes priority), col_cnt=0, stay in SEND.
    - Otherwise go to IDLE.
- Accepting into pnd: an accept while in SEND, and not coinciding with the last column being consumed, writes pnd and sets pnd_vld. If pnd and an incoming word both exist at reload, pnd moves to sft and the incoming word goes to pnd.
- o_rdy = ~pnd_vld. Sustained throughput is one word per ODATA_RNG cycles when i_rdy=1.
- o_data = sft[W*ODATA_RNG-1 -: W].
- Flags:
  - o_hstr/o_vstr = stored flag & (col_cnt==0) & o_dvld.
  - o_hend/o_vend = stored flag & (col_cnt==ODATA_RNG-1) & o_dvld.
- Stall: when i_rdy=0, sft, col_cnt and all outputs hold.
- Flags and data of a word are kept together; no reordering.

## Timing
- Reset (rst=1 at a clk edge):
  - State goes to IDLE; col_cnt=0 and pnd_vld=0; o_err=0.
  - o_dvld, o_hstr, o_vstr, o_hend, o_vend are 0; o_data is 0 (sft cleared).
  - o_rdy=1 in the first cycle after reset.
- Reset mid-word discards sft and pnd contents with no partial flush.
- Latency: word accepted at edge N drives its first column on o_data at cycle N+1. With i_rdy=1, column k appears at N+1+k.
- o_rdy depends on registered state only; there is no combinational path from i_dvld to o_rdy.
- Accept and last-column consume in the same cycle is gapless: o_dvld stays 1.
- i_dvld=1 while o_rdy=0 is a protocol violation. The word is dropped and pnd is unchanged.

## Configuration
- LINE_UNRNG_CHK_EN defined:
  - o_err port exists.
  - o_err sets one cycle after any cycle with i_dvld & ~o_rdy, and clears only on rst.
- Not defined: no o_err port and no check logic; behaviour is otherwise identical.

## Test plan
- Single word, defaults, i_data oldest slice = 48'hAAAA_AAAA_AAAA, newest = 48'h5555_5555_5555, i_hstr=1, i_hend=1, i_rdy=1 → cycle N+1: o_data=AAAA…, o_hstr=1. Cycle N+2: o_data=5555…, o_hend=1. Cycle N+3: o_dvld=0.
- Back-to-back words offered every cycle, honoring o_rdy → o_dvld continuous with no bubble; o_rdy duty is 1 of every 2 cycles; column order is preserved.
- i_rdy=0 for 3 cycles mid-word → o_data and flags hold; the remaining column follows once i_rdy=1; pnd is retained and o_rdy stays 0.
- ODATA_RNG=4, i_vstr=1 and i_vend=1 on the same word → o_vstr on column 0 only, o_vend on column 3 only.
- rst asserted while in SEND with pnd_vld=1 → next cycle o_dvld=0, o_rdy=1; the next word replays correctly from column 0.
- With LINE_UNRNG_CHK_EN: drive i_dvld while o_rdy=0 → o_err=1 the next cycle and stays 1 until rst; the dropped word never appears on o_data.
